latch_bank_write_ctrl: RTL and testbench
========================================

Name: latch_bank_write_ctrl

Overview:
Write scheduler for a bank of NLATCH gated D latches (D/G, Q/Qn cells). Shares the bank between NREQ requesters using round-robin arbitration. Each write is sequenced as data setup, then a gate pulse, then data hold, so no latch ever sees D change while G is high. Sits between the requester logic and the latch-bank datapath; it is the only driver of every latch D and G input.

Parameters:
NREQ, 4, number of requesters (>=2)
WIDTH, 8, data width per latch word
NLATCH, 4, number of latch words in the bank
AW, $clog2(NLATCH), address width (derived, not overridden)
GATE_CYCLES, 2, cycles G is held high per write (>=1; 0 is an elaboration error)

Ports:
clk  in  1  single clock, all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
req  in  NREQ  per-requester write request, level, held until ack
req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
req_data  in  NREQ*WIDTH  packed data, requester i at [i*WIDTH +: WIDTH]
ack  out  NREQ  one-cycle completion pulse to the granted requester
err  out  1  one-cycle pulse with ack when the address was >= NLATCH
latch_d  out  WIDTH  shared D bus to all latch words
latch_g  out  NLATCH  per-word gate, one-hot or zero
busy  out  1  high in every state except IDLE
grant_id  out  $clog2(NREQ)  index of the current or last granted requester

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
- Reset values (cycle after rst_n is sampled low): state=IDLE; latch_g=0; latch_d=0; ack=0; err=0; busy=0; grant_id=0. Round-robin pointer is set so requester 0 has top priority.
- Reset mid-write: G drops to 0 on the next edge with rst_n low, and no ack is issued. Contents of the target word are undefined.
- All outputs are Moore, decoded from registered state and captured registers. There is no combinational path from req, req_addr or req_data to any output.
- FSM states: IDLE, SETUP, OPEN, HOLD.
- IDLE:
  - If any req bit is high, pick the first set bit at or after ptr+1 (mod NREQ).
  - Capture that requester's addr and data; set grant_id; go to SETUP.
  - Otherwise stay in IDLE.
- SETUP (1 cycle): latch_d = captured data; latch_g = 0. Go to OPEN and load gate counter = GATE_CYCLES-1.
- OPEN (GATE_CYCLES cycles):
  - latch_g[addr] = 1 if addr < NLATCH, else latch_g = 0.
  - latch_d is held.
  - Counter decrements each cycle; at 0, go to HOLD.
- HOLD (1 cycle):
  - latch_g = 0; latch_d is held.
  - ack[grant_id] = 1 for this cycle only.
  - err = 1 if the address was out of range.
  - ptr <= grant_id; go to IDLE.
- Latency: req is sampled in IDLE cycle n; ack is high in cycle n+2+GATE_CYCLES (n+4 at default). The next grant can be made in cycle n+3+GATE_CYCLES.
- Data stability: latch_d is stable from SETUP through HOLD. This gives at least 1 cycle of setup before and 1 cycle of hold after every G pulse.
- Invariants:
  - At most one latch_g bit is high at any time.
  - latch_g is 0 outside OPEN.
  - ack and err are never high outside HOLD.
- Requester changes:
  - Changes to req, addr or data after capture are ignored.
  - If req drops before ack, the captured write still completes and ack still pulses.
  - If req stays high after ack, it counts as a new request, arbitrated with rotated priority.
- Simultaneous requests are served strictly round-robin. No requester waits more than NREQ-1 transactions.
- latch_d keeps its last value in IDLE; it is not returned to 0.

Decomposition:
- Package latch_ctrl_pkg holds:
  - the state enum (IDLE, SETUP, OPEN, HOLD);
  - the localparam for GATE counter width;
  - a function that decodes an address to a one-hot gate vector, with a range check.
- Sub-module rr_arbiter (NREQ): inputs req and ptr; outputs a grant index and a valid flag; purely combinational. It is instantiated once.

Test Plan:
- Single write: reset, then req[2]=1, addr=3, data=0xA5.
  - latch_d=0xA5 one cycle before latch_g=4'b1000.
  - latch_g is high exactly 2 cycles.
  - ack[2] pulses 4 cycles after sampling; err=0; the latch model's Q=0xA5.
- Contention: req=4'b1111 held continuously from reset.
  - Grants follow the order 0,1,2,3,0.
  - Each ack is 5 cycles apart.
  - latch_g never has 2 bits set.
- Early drop: req[1] deasserted in the SETUP cycle, with data changed to 0xFF.
  - The write of the original captured data still completes.
  - ack[1] still pulses.
- Out of range (NLATCH=3, AW=2): addr=3.
  - latch_g stays 0 throughout.
  - ack and err pulse together in HOLD.
- Reset mid-OPEN: rst_n=0 during the first OPEN cycle.
  - On the next edge: latch_g=0, busy=0, no ack.
  - After release, req[0] is granted first.
- GATE_CYCLES=1 build: the same single write gives ack 3 cycles after sampling, with the G pulse 1 cycle wide.

Source files
------------

// File: rtl/latch_ctrl_pkg.sv
// Shared types and helpers for the latch-bank write controller: FSM states,
// gate counter sizing and the address-to-gate decode with its range check.
package latch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    // The gate counter holds GATE_CYCLES-1, so this bounds GATE_CYCLES to 256.
    localparam int GATE_CNT_W      = 8;
    localparam int GATE_CYCLES_MAX = 1 << GATE_CNT_W;

    function automatic logic addr_in_range(input int addr, input int nlatch);
        return (addr >= 0) && (addr < nlatch);
    endfunction

    // One bit of the one-hot gate vector: word idx opens only for an in-range
    // address equal to idx, so an out-of-range address yields an all-zero vector.
    function automatic logic gate_onehot_bit(input int addr, input int idx, input int nlatch);
        return addr_in_range(addr, nlatch) && (addr == idx);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request strictly after ptr_i
// (wrapping), so the last winner has the lowest priority next time.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int GW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [GW-1:0]   ptr_i,
    output logic [GW-1:0]   grant_o,
    output logic            valid_o
);

    logic [GW-1:0] idx;
    logic          found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = GW'((int'(ptr_i) + k) % NREQ);
            if (!found && req_i[idx]) begin
                found   = 1'b1;
                grant_o = idx;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/latch_bank_write_ctrl.sv
// Round-robin write scheduler for a bank of gated D latches. Each write runs
// SETUP -> OPEN (G high GATE_CYCLES cycles) -> HOLD, so D never moves while G is high.
module latch_bank_write_ctrl
    import latch_ctrl_pkg::*;
#(
    parameter  int NREQ        = 4,
    parameter  int WIDTH       = 8,
    parameter  int NLATCH      = 4,
    parameter  int GATE_CYCLES = 2,
    localparam int AW          = (NLATCH > 1) ? $clog2(NLATCH) : 1,
    localparam int GW          = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*AW-1:0]      req_addr,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         ack,
    output logic                    err,
    output logic [WIDTH-1:0]        latch_d,
    output logic [NLATCH-1:0]       latch_g,
    output logic                    busy,
    output logic [GW-1:0]           grant_id
);

    // Handshake: req[i] is a level held with its addr/data until ack[i]; the
    // controller captures addr/data when it grants in IDLE and ignores any later
    // change, and ack[i] is a single-cycle pulse in HOLD that completes the write.

    if (GATE_CYCLES < 1) begin : g_bad_gate_cycles
        $error("latch_bank_write_ctrl: GATE_CYCLES must be at least 1");
    end
    if (GATE_CYCLES > GATE_CYCLES_MAX) begin : g_bad_gate_cycles_max
        $error("latch_bank_write_ctrl: GATE_CYCLES exceeds the gate counter range");
    end
    if (NREQ < 2) begin : g_bad_nreq
        $error("latch_bank_write_ctrl: NREQ must be at least 2");
    end

    state_e                 state_q, state_d;
    logic [GW-1:0]          ptr_q, ptr_d;
    logic [GW-1:0]          gid_q, gid_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic [GATE_CNT_W-1:0]  cnt_q, cnt_d;

    logic [GW-1:0]          arb_gnt;
    logic                   arb_vld;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (arb_gnt),
        .valid_o (arb_vld)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    gid_d   = arb_gnt;
                    addr_d  = req_addr[int'(arb_gnt)*AW +: AW];
                    data_d  = req_data[int'(arb_gnt)*WIDTH +: WIDTH];
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = GATE_CNT_W'(GATE_CYCLES - 1);
                state_d = OPEN;
            end
            OPEN: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                ptr_d   = gid_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pointer resets to the last requester so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= GW'(NREQ - 1);
            gid_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        latch_g = '0;
        ack     = '0;
        for (int i = 0; i < NLATCH; i++) begin
            latch_g[i] = (state_q == OPEN) && gate_onehot_bit(int'(addr_q), i, NLATCH);
        end
        for (int i = 0; i < NREQ; i++) begin
            ack[i] = (state_q == HOLD) && (gid_q == GW'(i));
        end
    end

    assign err      = (state_q == HOLD) && !addr_in_range(int'(addr_q), NLATCH);
    assign latch_d  = data_q;
    assign busy     = (state_q != IDLE);
    assign grant_id = gid_q;

endmodule

// File: tb/tb_latch_bank_write_ctrl.sv
// Bench for latch_bank_write_ctrl: three builds (default, NLATCH=3, GATE_CYCLES=1)
// driven one at a time; acks are scored against a queue of expected completions.
module tb_latch_bank_write_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  req_w  [3];
    logic [7:0]  addr_w;
    logic [31:0] data_w;
    logic [3:0]  ack_w  [3];
    logic        err_w  [3];
    logic [7:0]  d_w    [3];
    logic        busy_w [3];
    logic [1:0]  gid_w  [3];
    logic [3:0]  g0, g2;
    logic [2:0]  g1;
    logic [3:0]  g_w    [3];

    assign g_w[0] = g0;
    assign g_w[1] = {1'b0, g1};
    assign g_w[2] = g2;

    latch_bank_write_ctrl #(.NREQ(4), .WIDTH(8), .NLATCH(4), .GATE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req_w[0]), .req_addr(addr_w), .req_data(data_w),
        .ack(ack_w[0]), .err(err_w[0]), .latch_d(d_w[0]), .latch_g(g0),
        .busy(busy_w[0]), .grant_id(gid_w[0])
    );

    latch_bank_write_ctrl #(.NREQ(4), .WIDTH(8), .NLATCH(3), .GATE_CYCLES(2)) dut_n3 (
        .clk(clk), .rst_n(rst_n), .req(req_w[1]), .req_addr(addr_w), .req_data(data_w),
        .ack(ack_w[1]), .err(err_w[1]), .latch_d(d_w[1]), .latch_g(g1),
        .busy(busy_w[1]), .grant_id(gid_w[1])
    );

    latch_bank_write_ctrl #(.NREQ(4), .WIDTH(8), .NLATCH(4), .GATE_CYCLES(1)) dut_g1 (
        .clk(clk), .rst_n(rst_n), .req(req_w[2]), .req_addr(addr_w), .req_data(data_w),
        .ack(ack_w[2]), .err(err_w[2]), .latch_d(d_w[2]), .latch_g(g2),
        .busy(busy_w[2]), .grant_id(gid_w[2])
    );

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic rst_seen;

    // Expected completion: {ack cycle[15:0], dut[1:0], grant[1:0], err, data[7:0]}
    logic [28:0] exp_q[$];
    logic [28:0] mon_e;

    logic [7:0]  bank   [3][4];
    logic [7:0]  prev_d [3];
    logic [3:0]  prev_g [3];
    int          gw     [3];

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst_n;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic put(input int i, input logic [1:0] a, input logic [7:0] v);
        addr_w[i*2 +: 2] = a;
        data_w[i*8 +: 8] = v;
    endtask

    task automatic push(input int d, input int c, input int gid, input logic e, input logic [7:0] v);
        exp_q.push_back({16'(c), 2'(d), 2'(gid), e, v});
    endtask

    // Monitor: scores every ack against the queue and tracks gate/data timing.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ack_w[d] != 4'b0 || err_w[d]) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_ack dut=%0d cycle=%0d: actual ack=%b err=%b required none",
                             d, cyc, ack_w[d], err_w[d]);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ack_dut", d, 32'(mon_e[12:11]));
                    check("ack_cycle", cyc, 32'(mon_e[28:13]));
                    check("ack_vector", 32'(ack_w[d]), 32'(1) << mon_e[10:9]);
                    check("err", 32'(err_w[d]), 32'(mon_e[8]));
                    check("grant_id", 32'(gid_w[d]), 32'(mon_e[10:9]));
                    check("latch_d_at_ack", 32'(d_w[d]), 32'(mon_e[7:0]));
                end
            end
            if (g_w[d] != 4'b0) begin
                check("gate_onehot", $countones(g_w[d]), 1);
                if (prev_g[d] == 4'b0) begin
                    check("d_setup", 32'(d_w[d]), 32'(prev_d[d]));
                    gw[d] = 1;
                end else begin
                    check("d_stable_g_high", 32'(d_w[d]), 32'(prev_d[d]));
                    check("g_same_word", 32'(g_w[d]), 32'(prev_g[d]));
                    gw[d]++;
                end
                for (int i = 0; i < 4; i++) if (g_w[d][i]) bank[d][i] = d_w[d];
            end else if (prev_g[d] != 4'b0 && rst_seen) begin
                check("g_width", gw[d], (d == 2) ? 1 : 2);
                check("d_hold", 32'(d_w[d]), 32'(prev_d[d]));
            end
            prev_g[d] = g_w[d];
            prev_d[d] = d_w[d];
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: actual=timeout required=completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        int p;
        for (int d = 0; d < 3; d++) begin
            req_w[d]  = 4'b0;
            prev_d[d] = 8'h0;
            prev_g[d] = 4'b0;
            gw[d]     = 0;
            for (int i = 0; i < 4; i++) bank[d][i] = 8'h0;
        end
        rst_n  = 1'b0;
        addr_w = 8'h0;
        data_w = 32'h0;
        repeat (2) @(negedge clk);

        for (int d = 0; d < 3; d++) begin
            check("rst_latch_g", 32'(g_w[d]), 0);
            check("rst_latch_d", 32'(d_w[d]), 0);
            check("rst_ack", 32'(ack_w[d]), 0);
            check("rst_err", 32'(err_w[d]), 0);
            check("rst_busy", 32'(busy_w[d]), 0);
            check("rst_grant_id", 32'(gid_w[d]), 0);
        end

        // Single write: requester 2 -> word 3. p is the edge that samples req.
        rst_n = 1'b1;
        put(2, 2'd3, 8'hA5);
        req_w[0] = 4'b0100;
        p = cyc + 1;
        push(0, p + 3, 2, 1'b0, 8'hA5);
        wait_until(p);
        check("setup_d", 32'(d_w[0]), 32'h A5);
        check("setup_g", 32'(g_w[0]), 0);
        check("setup_busy", 32'(busy_w[0]), 1);
        wait_until(p + 1);
        check("open_g", 32'(g_w[0]), 32'b1000);
        wait_until(p + 3);
        req_w[0] = 4'b0;
        wait_until(p + 4);
        check("single_q", 32'(bank[0][3]), 32'hA5);
        check("idle_busy", 32'(busy_w[0]), 0);

        // Contention: all four held from reset, grants 0,1,2,3,0 five cycles apart.
        rst_n = 1'b0;
        req_w[0] = 4'b1111;
        for (int i = 0; i < 4; i++) put(i, 2'(i), 8'(16 + i));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        p = cyc + 1;
        for (int k = 0; k < 5; k++) push(0, p + 3 + 5 * k, k % 4, 1'b0, 8'(16 + k % 4));
        wait_until(p + 23);
        req_w[0] = 4'b0;
        wait_until(p + 25);
        for (int i = 0; i < 4; i++) check("rr_q", 32'(bank[0][i]), 32'(16 + i));

        // Early drop: req[1] falls in SETUP and its data changes; the captured write completes.
        put(1, 2'd1, 8'h3C);
        req_w[0] = 4'b0010;
        p = cyc + 1;
        push(0, p + 3, 1, 1'b0, 8'h3C);
        wait_until(p);
        req_w[0] = 4'b0;
        put(1, 2'd1, 8'hFF);
        wait_until(p + 5);
        check("drop_q", 32'(bank[0][1]), 32'h3C);

        // Reset in the first OPEN cycle; afterwards requester 0 beats requester 3.
        put(3, 2'd2, 8'h77);
        req_w[0] = 4'b1000;
        p = cyc + 1;
        wait_until(p + 1);
        check("open_before_rst", 32'(g_w[0]), 32'b0100);
        rst_n = 1'b0;
        req_w[0] = 4'b1001;
        put(0, 2'd0, 8'h5A);
        @(negedge clk);
        check("midrst_g", 32'(g_w[0]), 0);
        check("midrst_busy", 32'(busy_w[0]), 0);
        check("midrst_ack", 32'(ack_w[0]), 0);
        check("midrst_grant_id", 32'(gid_w[0]), 0);
        rst_n = 1'b1;
        p = cyc + 1;
        push(0, p + 3, 0, 1'b0, 8'h5A);
        push(0, p + 8, 3, 1'b0, 8'h77);
        wait_until(p + 3);
        req_w[0] = 4'b1000;
        wait_until(p + 8);
        req_w[0] = 4'b0;
        wait_until(p + 10);
        check("postrst_q0", 32'(bank[0][0]), 32'h5A);
        check("postrst_q2", 32'(bank[0][2]), 32'h77);

        // NLATCH=3 build: address 3 is out of range, then an in-range write.
        put(0, 2'd3, 8'hC3);
        req_w[1] = 4'b0001;
        p = cyc + 1;
        push(1, p + 3, 0, 1'b1, 8'hC3);
        wait_until(p + 1);
        check("oor_g", 32'(g_w[1]), 0);
        check("oor_busy", 32'(busy_w[1]), 1);
        wait_until(p + 3);
        req_w[1] = 4'b0;
        wait_until(p + 5);
        put(1, 2'd2, 8'h42);
        req_w[1] = 4'b0010;
        p = cyc + 1;
        push(1, p + 3, 1, 1'b0, 8'h42);
        wait_until(p + 1);
        check("n3_open_g", 32'(g_w[1]), 32'b0100);
        wait_until(p + 3);
        req_w[1] = 4'b0;
        wait_until(p + 5);
        check("n3_q", 32'(bank[1][2]), 32'h42);

        // GATE_CYCLES=1 build: ack three cycles after sampling, one-cycle gate.
        put(2, 2'd3, 8'hA5);
        req_w[2] = 4'b0100;
        p = cyc + 1;
        push(2, p + 2, 2, 1'b0, 8'hA5);
        wait_until(p + 1);
        check("g1_open_g", 32'(g_w[2]), 32'b1000);
        wait_until(p + 2);
        req_w[2] = 4'b0;
        check("g1_hold_g", 32'(g_w[2]), 0);
        wait_until(p + 4);
        check("g1_q", 32'(bank[2][3]), 32'hA5);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
